game_ctrl_multi: RTL and testbench

GAME_CTRL_MULTI -- requirements
Module: game_ctrl_multi

---
 rtl/game_ctrl_pkg.sv | 19 +
 rtl/turn_timer.sv | 45 ++++
 rtl/game_ctrl_multi.sv | 156 +++++++++++++++
 tb/tb_game_ctrl_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared encodings for the multi-player game controller: FSM state codes
// and the idle keypad code from which each instance derives its NO_KEY.
package game_ctrl_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE      = 4'd0;
  localparam logic [STATE_W-1:0] ST_SELECT    = 4'd1;
  localparam logic [STATE_W-1:0] ST_ARM       = 4'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_KEY  = 4'd3;
  localparam logic [STATE_W-1:0] ST_CHECK     = 4'd4;
  localparam logic [STATE_W-1:0] ST_MOVE      = 4'd5;
  localparam logic [STATE_W-1:0] ST_WIN_CHECK = 4'd6;
  localparam logic [STATE_W-1:0] ST_DONE      = 4'd7;

  // Wide all-ones source; instances slice it to KEY_W bits.
  localparam logic [31:0] NO_KEY_ALL_ONES = '1;

endpackage

// File: rtl/turn_timer.sv
// Reloadable down-counter for the per-turn key timeout. expire strobes during
// the last counting cycle; the counter collapses to constants when TIMEOUT=0.
module turn_timer #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = clk ^ rst ^ load ^ run;
      assign expire        = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT + 1);

      logic [CW-1:0] count_q, count_d;

      always_comb begin
        count_d = count_q;
        if (load) begin
          count_d = CW'(TIMEOUT);
        end else if (run && (count_q != '0)) begin
          count_d = count_q - CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      // A value of 1 marks the TIMEOUT-th cycle spent waiting since the reload.
      assign expire = run && (count_q == CW'(1));
    end
  endgenerate

endmodule

// File: rtl/game_ctrl_multi.sv
// Turn-based game controller: target selection, per-player key/flip turns,
// match and win handshakes, optional turn timeout, registered outputs.
module game_ctrl_multi
  import game_ctrl_pkg::*;
#(
  parameter int                NUM_PLAYERS = 2,
  parameter int                KEY_W       = 4,
  parameter logic [KEY_W-1:0]  NO_KEY      = NO_KEY_ALL_ONES[KEY_W-1:0],
  parameter int unsigned       TIMEOUT     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [KEY_W-1:0]               key,
  input  logic                           start,
  input  logic                           go_valid,
  input  logic                           go,
  input  logic                           win_valid,
  input  logic                           win,
  output logic                           flip,
  output logic                           move,
  output logic [KEY_W-1:0]               n_sel,
  output logic [$clog2(NUM_PLAYERS)-1:0] player,
  output logic [3:0]                     state,
  output logic                           done,
  output logic [$clog2(NUM_PLAYERS)-1:0] winner
);

  localparam int PW = $clog2(NUM_PLAYERS);

  logic [STATE_W-1:0] state_q, state_d;
  logic [KEY_W-1:0]   n_sel_q, n_sel_d;
  logic [PW-1:0]      player_q, player_d;
  logic [PW-1:0]      winner_q, winner_d;
  logic [PW-1:0]      player_next;
  logic               flip_q, flip_d;
  logic               move_q, move_d;
  logic               done_q, done_d;

  logic key_hit;
  logic tmr_load;
  logic tmr_run;
  logic tmr_expire;

  assign key_hit     = (key != NO_KEY);
  assign player_next = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + PW'(1);

  // Timer reloads on the release that leaves ARM and counts only in WAIT_KEY.
  assign tmr_load = (state_q == ST_ARM) && !key_hit;
  assign tmr_run  = (state_q == ST_WAIT_KEY);

  turn_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_turn_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .run    (tmr_run),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    n_sel_d  = n_sel_q;
    player_d = player_q;
    winner_d = winner_q;
    flip_d   = 1'b0;
    move_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (key_hit) begin
          n_sel_d  = key;
          player_d = '0;
          state_d  = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!key_hit) state_d = ST_WAIT_KEY;
      end
      ST_WAIT_KEY: begin
        // A key arriving on the expiry cycle still counts as a valid press.
        if (key_hit) begin
          flip_d  = 1'b1;
          state_d = ST_CHECK;
        end else if (tmr_expire) begin
          player_d = player_next;
          state_d  = ST_ARM;
        end
      end
      ST_CHECK: begin
        if (go_valid) begin
          if (go) begin
            move_d  = 1'b1;
            state_d = ST_MOVE;
          end else begin
            player_d = player_next;
            state_d  = ST_ARM;
          end
        end
      end
      ST_MOVE: begin
        state_d = ST_WIN_CHECK;
      end
      ST_WIN_CHECK: begin
        if (win_valid) begin
          if (win) begin
            winner_d = player_q;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_ARM;
          end
        end
      end
      ST_DONE: begin
        if (start) state_d = ST_SELECT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      n_sel_q  <= '0;
      player_q <= '0;
      winner_q <= '0;
      flip_q   <= 1'b0;
      move_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_sel_q  <= n_sel_d;
      player_q <= player_d;
      winner_q <= winner_d;
      flip_q   <= flip_d;
      move_q   <= move_d;
      done_q   <= done_d;
    end
  end

  assign state  = state_q;
  assign n_sel  = n_sel_q;
  assign player = player_q;
  assign winner = winner_q;
  assign flip   = flip_q;
  assign move   = move_q;
  assign done   = done_q;

endmodule

// File: tb/tb_game_ctrl_multi.sv
// Directed bench for game_ctrl_multi with three players and an 8-cycle timeout.
module tb_game_ctrl_multi;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SELECT    = 4'd1;
  localparam logic [3:0] S_ARM       = 4'd2;
  localparam logic [3:0] S_WAIT_KEY  = 4'd3;
  localparam logic [3:0] S_CHECK     = 4'd4;
  localparam logic [3:0] S_MOVE      = 4'd5;
  localparam logic [3:0] S_WIN_CHECK = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] IDLE_KEY    = 4'hF;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic       start, go_valid, go, win_valid, win;
  logic       flip, move, done;
  logic [3:0] n_sel;
  logic [1:0] player, winner;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int flip_cnt = 0;
  int move_cnt = 0;

  game_ctrl_multi #(
    .NUM_PLAYERS (3),
    .KEY_W       (4),
    .NO_KEY      (4'hF),
    .TIMEOUT     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .start     (start),
    .go_valid  (go_valid),
    .go        (go),
    .win_valid (win_valid),
    .win       (win),
    .flip      (flip),
    .move      (move),
    .n_sel     (n_sel),
    .player    (player),
    .state     (state),
    .done      (done),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (flip) flip_cnt++;
    if (move) move_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (state  !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0h want %0h", state, S_IDLE); end
    n_tests++; if (flip   !== 1'b0)   begin n_fail++; $display("FAIL reset_flip got %b want 0", flip); end
    n_tests++; if (move   !== 1'b0)   begin n_fail++; $display("FAIL reset_move got %b want 0", move); end
    n_tests++; if (n_sel  !== 4'h0)   begin n_fail++; $display("FAIL reset_n_sel got %0h want 0", n_sel); end
    n_tests++; if (player !== 2'd0)   begin n_fail++; $display("FAIL reset_player got %0d want 0", player); end
    n_tests++; if (done   !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (winner !== 2'd0)   begin n_fail++; $display("FAIL reset_winner got %0d want 0", winner); end
    rst = 1'b0;
    $display("[TB] reset: state=%0h player=%0d", state, player);
  endtask

  task automatic test_select_flip();
    int f0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (state !== S_SELECT) begin n_fail++; $display("FAIL start_to_select got %0h want %0h", state, S_SELECT); end
    key = 4'h3;
    tick();
    n_tests++; if (state !== S_ARM) begin n_fail++; $display("FAIL select_to_arm got %0h want %0h", state, S_ARM); end
    n_tests++; if (n_sel !== 4'h3)  begin n_fail++; $display("FAIL n_sel_latch got %0h want 3", n_sel); end
    f0 = flip_cnt;
    repeat (3) tick();
    n_tests++; if (state !== S_ARM) begin n_fail++; $display("FAIL arm_hold_key got %0h want %0h", state, S_ARM); end
    key = IDLE_KEY;
    tick();
    n_tests++; if (state !== S_WAIT_KEY) begin n_fail++; $display("FAIL arm_release got %0h want %0h", state, S_WAIT_KEY); end
    key = 4'h5;
    tick();
    n_tests++; if (state !== S_CHECK) begin n_fail++; $display("FAIL key_to_check got %0h want %0h", state, S_CHECK); end
    n_tests++; if (flip !== 1'b1)     begin n_fail++; $display("FAIL flip_pulse got %b want 1", flip); end
    repeat (9) tick();
    n_tests++; if ((flip_cnt - f0) !== 1) begin n_fail++; $display("FAIL flip_count_held got %0d want 1", flip_cnt - f0); end
    n_tests++; if (flip !== 1'b0)         begin n_fail++; $display("FAIL flip_low_after got %b want 0", flip); end
    n_tests++; if (n_sel !== 4'h3)        begin n_fail++; $display("FAIL n_sel_stable got %0h want 3", n_sel); end
    $display("[TB] select/flip: n_sel=%0h flips=%0d state=%0h", n_sel, flip_cnt - f0, state);
  endtask

  task automatic test_rotation();
    logic [1:0] exp_p [3] = '{2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 3; i++) begin
      key      = IDLE_KEY;
      go_valid = 1'b1;
      go       = 1'b0;
      tick();
      go_valid = 1'b0;
      n_tests++; if (state !== S_ARM)     begin n_fail++; $display("FAIL reject_state[%0d] got %0h want %0h", i, state, S_ARM); end
      n_tests++; if (player !== exp_p[i]) begin n_fail++; $display("FAIL rotate_player[%0d] got %0d want %0d", i, player, exp_p[i]); end
      $display("[TB] rotation %0d: player=%0d", i, player);
      if (i < 2) begin
        tick();
        key = 4'h5;
        tick();
      end
    end
  endtask

  task automatic test_ignore();
    tick();
    n_tests++; if (state !== S_WAIT_KEY) begin n_fail++; $display("FAIL ignore_setup got %0h want %0h", state, S_WAIT_KEY); end
    go_valid = 1'b1; go = 1'b1; win_valid = 1'b1; win = 1'b1; start = 1'b1;
    tick();
    go_valid = 1'b0; go = 1'b0; win_valid = 1'b0; win = 1'b0; start = 1'b0;
    n_tests++; if (state !== S_WAIT_KEY) begin n_fail++; $display("FAIL ignore_state got %0h want %0h", state, S_WAIT_KEY); end
    n_tests++; if (player !== 2'd0)      begin n_fail++; $display("FAIL ignore_player got %0d want 0", player); end
    n_tests++; if (move !== 1'b0)        begin n_fail++; $display("FAIL ignore_move got %b want 0", move); end
    key = 4'h6;
    tick();
    $display("[TB] ignore: state=%0h player=%0d", state, player);
  endtask

  task automatic test_win();
    int m0;
    for (int i = 0; i < 2; i++) begin
      key = IDLE_KEY; go_valid = 1'b1; go = 1'b0;
      tick();
      go_valid = 1'b0;
      tick();
      key = 4'h6;
      tick();
    end
    n_tests++; if (state !== S_CHECK) begin n_fail++; $display("FAIL win_setup_state got %0h want %0h", state, S_CHECK); end
    n_tests++; if (player !== 2'd2)   begin n_fail++; $display("FAIL win_setup_player got %0d want 2", player); end
    m0 = move_cnt;
    key = IDLE_KEY; go_valid = 1'b1; go = 1'b1;
    tick();
    go_valid = 1'b0; go = 1'b0;
    n_tests++; if (state !== S_MOVE)  begin n_fail++; $display("FAIL match_state got %0h want %0h", state, S_MOVE); end
    n_tests++; if (move !== 1'b1)     begin n_fail++; $display("FAIL move_pulse got %b want 1", move); end
    n_tests++; if (flip !== 1'b0)     begin n_fail++; $display("FAIL flip_with_move got %b want 0", flip); end
    n_tests++; if (player !== 2'd2)   begin n_fail++; $display("FAIL move_player got %0d want 2", player); end
    tick();
    n_tests++; if (state !== S_WIN_CHECK) begin n_fail++; $display("FAIL move_to_wincheck got %0h want %0h", state, S_WIN_CHECK); end
    n_tests++; if (move !== 1'b0)         begin n_fail++; $display("FAIL move_one_cycle got %b want 0", move); end
    repeat (2) tick();
    n_tests++; if (state !== S_WIN_CHECK) begin n_fail++; $display("FAIL wincheck_hold got %0h want %0h", state, S_WIN_CHECK); end
    win_valid = 1'b1; win = 1'b0;
    tick();
    win_valid = 1'b0;
    n_tests++; if (state !== S_ARM)   begin n_fail++; $display("FAIL nowin_state got %0h want %0h", state, S_ARM); end
    n_tests++; if (player !== 2'd2)   begin n_fail++; $display("FAIL nowin_player got %0d want 2", player); end
    tick();
    key = 4'h6;
    tick();
    key = IDLE_KEY; go_valid = 1'b1; go = 1'b1;
    tick();
    go_valid = 1'b0; go = 1'b0;
    tick();
    win_valid = 1'b1; win = 1'b1;
    tick();
    win_valid = 1'b0; win = 1'b0;
    n_tests++; if (state !== S_DONE)         begin n_fail++; $display("FAIL win_state got %0h want %0h", state, S_DONE); end
    n_tests++; if (done !== 1'b1)            begin n_fail++; $display("FAIL win_done got %b want 1", done); end
    n_tests++; if (winner !== 2'd2)          begin n_fail++; $display("FAIL win_winner got %0d want 2", winner); end
    n_tests++; if ((move_cnt - m0) !== 2)    begin n_fail++; $display("FAIL move_count got %0d want 2", move_cnt - m0); end
    repeat (3) tick();
    n_tests++; if (done !== 1'b1 || winner !== 2'd2) begin n_fail++; $display("FAIL done_hold got done=%b winner=%0d want done=1 winner=2", done, winner); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++; if (state !== S_SELECT) begin n_fail++; $display("FAIL restart_state got %0h want %0h", state, S_SELECT); end
    n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL restart_done got %b want 0", done); end
    $display("[TB] win: winner=%0d moves=%0d state=%0h", winner, move_cnt - m0, state);
  endtask

  task automatic test_timeout();
    int f0;
    key = 4'h7;
    tick();
    key = IDLE_KEY;
    tick();
    n_tests++; if (state !== S_WAIT_KEY) begin n_fail++; $display("FAIL to_setup got %0h want %0h", state, S_WAIT_KEY); end
    f0 = flip_cnt;
    repeat (7) tick();
    n_tests++; if (state !== S_WAIT_KEY) begin n_fail++; $display("FAIL to_early got %0h want %0h", state, S_WAIT_KEY); end
    n_tests++; if (player !== 2'd0)      begin n_fail++; $display("FAIL to_early_player got %0d want 0", player); end
    tick();
    n_tests++; if (state !== S_ARM)      begin n_fail++; $display("FAIL to_expire_state got %0h want %0h", state, S_ARM); end
    n_tests++; if (player !== 2'd1)      begin n_fail++; $display("FAIL to_expire_player got %0d want 1", player); end
    n_tests++; if (flip_cnt !== f0)      begin n_fail++; $display("FAIL to_no_flip got %0d want %0d", flip_cnt, f0); end
    tick();
    repeat (7) tick();
    n_tests++; if (state !== S_WAIT_KEY) begin n_fail++; $display("FAIL to_reload got %0h want %0h", state, S_WAIT_KEY); end
    key = 4'h9;
    tick();
    n_tests++; if (state !== S_CHECK)    begin n_fail++; $display("FAIL to_key_wins_state got %0h want %0h", state, S_CHECK); end
    n_tests++; if (flip !== 1'b1)        begin n_fail++; $display("FAIL to_key_wins_flip got %b want 1", flip); end
    n_tests++; if (player !== 2'd1)      begin n_fail++; $display("FAIL to_key_wins_player got %0d want 1", player); end
    $display("[TB] timeout: player=%0d state=%0h flip=%b", player, state, flip);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; go_valid = 1'b1; go = 1'b1; start = 1'b1;
    tick();
    n_tests++; if (state !== S_IDLE) begin n_fail++; $display("FAIL rmid_state got %0h want %0h", state, S_IDLE); end
    n_tests++; if (flip !== 1'b0)    begin n_fail++; $display("FAIL rmid_flip got %b want 0", flip); end
    n_tests++; if (move !== 1'b0)    begin n_fail++; $display("FAIL rmid_move got %b want 0", move); end
    n_tests++; if (n_sel !== 4'h0)   begin n_fail++; $display("FAIL rmid_n_sel got %0h want 0", n_sel); end
    n_tests++; if (player !== 2'd0)  begin n_fail++; $display("FAIL rmid_player got %0d want 0", player); end
    n_tests++; if (winner !== 2'd0)  begin n_fail++; $display("FAIL rmid_winner got %0d want 0", winner); end
    n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL rmid_done got %b want 0", done); end
    rst = 1'b0; go_valid = 1'b0; go = 1'b0; start = 1'b0; key = IDLE_KEY;
    tick();
    n_tests++; if (state !== S_IDLE) begin n_fail++; $display("FAIL rmid_stay_idle got %0h want %0h", state, S_IDLE); end
    $display("[TB] reset mid-turn: state=%0h", state);
  endtask

  initial begin
    rst = 1'b1; key = IDLE_KEY; start = 1'b0;
    go_valid = 1'b0; go = 1'b0; win_valid = 1'b0; win = 1'b0;
    test_reset();
    test_select_flip();
    test_rotation();
    test_ignore();
    test_win();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
